ctrl_pipe_unit: RTL and testbench

//  Parametrised decode/control stage for the ARM-subset pipeline. Decodes mode/op_code/S/I,

---
 rtl/ctrl_pipe_unit.sv | 201 ++++++++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: decode/control stage for the ARM-subset pipeline.
// Decodes mode/op_code/S/I and evaluates the condition field against NZCV.
// The resulting control word is registered into the ID/EX control register,
// with freeze/flush handling and a branch-shadow squash counter.
module ctrl_pipe_unit #(
    parameter int unsigned EXE_CMD_W     = 4,
    parameter int unsigned BRANCH_SHADOW = 1,
    parameter int unsigned CNT_W         = 16,
    parameter bit          COND_EN       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [1:0]           mode,
    input  logic [3:0]           op_code,
    input  logic                 S,
    input  logic                 immediate,
    input  logic [3:0]           cond,
    input  logic [3:0]           status,
    input  logic                 freeze,
    input  logic                 flush,
    output logic                 ex_valid,
    output logic [EXE_CMD_W-1:0] ex_exe_command,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_wb_enable,
    output logic                 ex_is_immediate,
    output logic                 ex_B,
    output logic                 ex_update_status,
    output logic                 undef_instr,
    output logic                 shadow_active,
    output logic [CNT_W-1:0]     issued_count
);

    localparam logic [2:0] ShadowInit = 3'(BRANCH_SHADOW);

    typedef enum logic [1:0] {
        ModeDataProc = 2'd0,
        ModeMem      = 2'd1,
        ModeBranch   = 2'd2,
        ModeUndef    = 2'd3
    } mode_e;

    // Decoded (combinational) control word
    logic [3:0] dec_cmd;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_wb;
    logic       dec_imm;
    logic       dec_b;
    logic       dec_us;
    logic       dec_undef;

    logic cond_raw;
    logic cond_pass;
    logic live;

    // Registered ID/EX state
    logic                 valid_q;
    logic [EXE_CMD_W-1:0] cmd_q;
    logic                 mem_read_q;
    logic                 mem_write_q;
    logic                 wb_q;
    logic                 imm_q;
    logic                 b_q;
    logic                 us_q;
    logic                 undef_q;
    logic [2:0]           shadow_q;
    logic [CNT_W-1:0]     count_q;

    // Decode mode/op_code/S/I into the control word; everything defaults to 0
    always_comb begin
        dec_cmd       = 4'b0000;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_wb        = 1'b0;
        dec_imm       = 1'b0;
        dec_b         = 1'b0;
        dec_us        = 1'b0;
        dec_undef     = 1'b0;
        unique case (mode_e'(mode))
            ModeDataProc: begin
                dec_wb  = 1'b1;
                dec_imm = immediate;
                dec_us  = S;
                case (op_code)
                    4'b1101: dec_cmd = 4'b0001;                   // MOV
                    4'b1111: dec_cmd = 4'b1001;                   // MVN
                    4'b0100: dec_cmd = 4'b0010;                   // ADD
                    4'b0101: dec_cmd = 4'b0011;                   // ADC
                    4'b0010: dec_cmd = 4'b0100;                   // SUB
                    4'b0110: dec_cmd = 4'b0101;                   // SBC
                    4'b0000: dec_cmd = 4'b0110;                   // AND
                    4'b1100: dec_cmd = 4'b0111;                   // ORR
                    4'b0001: dec_cmd = 4'b1000;                   // EOR
                    4'b1010: begin dec_cmd = 4'b0100; dec_wb = 1'b0; end  // CMP
                    4'b1000: begin dec_cmd = 4'b0110; dec_wb = 1'b0; end  // TST
                    default: dec_cmd = 4'b0000;
                endcase
            end
            ModeMem: begin
                dec_cmd       = 4'b0010;
                dec_imm       = immediate;
                dec_mem_read  = S;
                dec_wb        = S;
                dec_mem_write = ~S;
            end
            ModeBranch: dec_b = 1'b1;
            ModeUndef:  dec_undef = 1'b1;
            default:    dec_undef = 1'b0;
        endcase
    end

    // Evaluate the ARM condition field against {N,Z,C,V}
    always_comb begin
        cond_raw = 1'b0;
        case (cond)
            4'h0: cond_raw = status[2];
            4'h1: cond_raw = ~status[2];
            4'h2: cond_raw = status[1];
            4'h3: cond_raw = ~status[1];
            4'h4: cond_raw = status[3];
            4'h5: cond_raw = ~status[3];
            4'h6: cond_raw = status[0];
            4'h7: cond_raw = ~status[0];
            4'h8: cond_raw = status[1] & ~status[2];
            4'h9: cond_raw = ~status[1] | status[2];
            4'ha: cond_raw = (status[3] == status[0]);
            4'hb: cond_raw = (status[3] != status[0]);
            4'hc: cond_raw = ~status[2] & (status[3] == status[0]);
            4'hd: cond_raw = status[2] | (status[3] != status[0]);
            4'he: cond_raw = 1'b1;
            4'hf: cond_raw = 1'b0;
        endcase
    end

    assign cond_pass = COND_EN ? cond_raw : 1'b1;
    // Slots in the branch shadow are squashed regardless of their condition
    assign live      = id_valid & cond_pass & (shadow_q == 3'd0);

    // ID/EX register, shadow counter and issue counter: rst > flush > freeze > load
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            cmd_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            wb_q        <= 1'b0;
            imm_q       <= 1'b0;
            b_q         <= 1'b0;
            us_q        <= 1'b0;
            undef_q     <= 1'b0;
            shadow_q    <= 3'd0;
            count_q     <= '0;
        end else if (flush) begin
            valid_q     <= 1'b0;
            cmd_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            wb_q        <= 1'b0;
            imm_q       <= 1'b0;
            b_q         <= 1'b0;
            us_q        <= 1'b0;
            undef_q     <= 1'b0;
            shadow_q    <= 3'd0;
        end else if (freeze) begin
            undef_q <= 1'b0;
        end else begin
            valid_q     <= live;
            cmd_q       <= live ? EXE_CMD_W'(dec_cmd) : '0;
            mem_read_q  <= live & dec_mem_read;
            mem_write_q <= live & dec_mem_write;
            wb_q        <= live & dec_wb;
            imm_q       <= live & dec_imm;
            b_q         <= live & dec_b;
            us_q        <= live & dec_us;
            undef_q     <= live & dec_undef;
            if (live && dec_b) begin
                shadow_q <= ShadowInit;
            end else if (shadow_q != 3'd0) begin
                shadow_q <= shadow_q - 3'd1;
            end
            if (live) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign ex_valid         = valid_q;
    assign ex_exe_command   = cmd_q;
    assign ex_mem_read      = mem_read_q;
    assign ex_mem_write     = mem_write_q;
    assign ex_wb_enable     = wb_q;
    assign ex_is_immediate  = imm_q;
    assign ex_B             = b_q;
    assign ex_update_status = us_q;
    assign undef_instr      = undef_q;
    assign shadow_active    = (shadow_q != 3'd0);
    assign issued_count     = count_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Self-checking bench for ctrl_pipe_unit: directed steps then randomized
// traffic, all compared against a behavioural model of the control stage.
module tb_ctrl_pipe_unit;

    localparam int unsigned EXE_CMD_W     = 4;
    localparam int unsigned BRANCH_SHADOW = 1;
    localparam int unsigned CNT_W         = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 id_valid = 1'b0;
    logic [1:0]           mode = 2'd0;
    logic [3:0]           op_code = 4'd0;
    logic                 S = 1'b0;
    logic                 immediate = 1'b0;
    logic [3:0]           cond = 4'he;
    logic [3:0]           status = 4'd0;
    logic                 freeze = 1'b0;
    logic                 flush = 1'b0;
    logic                 ex_valid;
    logic [EXE_CMD_W-1:0] ex_exe_command;
    logic                 ex_mem_read;
    logic                 ex_mem_write;
    logic                 ex_wb_enable;
    logic                 ex_is_immediate;
    logic                 ex_B;
    logic                 ex_update_status;
    logic                 undef_instr;
    logic                 shadow_active;
    logic [CNT_W-1:0]     issued_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit       m_valid, m_rd, m_wr, m_wb, m_imm, m_b, m_us, m_undef;
    bit [3:0] m_cmd;
    int       m_shadow;
    int       m_count;

    ctrl_pipe_unit #(
        .EXE_CMD_W    (EXE_CMD_W),
        .BRANCH_SHADOW(BRANCH_SHADOW),
        .CNT_W        (CNT_W),
        .COND_EN      (1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .mode            (mode),
        .op_code         (op_code),
        .S               (S),
        .immediate       (immediate),
        .cond            (cond),
        .status          (status),
        .freeze          (freeze),
        .flush           (flush),
        .ex_valid        (ex_valid),
        .ex_exe_command  (ex_exe_command),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_wb_enable    (ex_wb_enable),
        .ex_is_immediate (ex_is_immediate),
        .ex_B            (ex_B),
        .ex_update_status(ex_update_status),
        .undef_instr     (undef_instr),
        .shadow_active   (shadow_active),
        .issued_count    (issued_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit cond_ok(input bit [3:0] c, input bit [3:0] nzcv);
        bit n, z, cf, v;
        {n, z, cf, v} = nzcv;
        case (c)
            0: return z;          1: return !z;
            2: return cf;         3: return !cf;
            4: return n;          5: return !n;
            6: return v;          7: return !v;
            8: return cf && !z;   9: return !cf || z;
            10: return n == v;    11: return n != v;
            12: return !z && n == v;
            13: return z || n != v;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_clock();
        bit live;
        if (rst) begin
            {m_valid, m_rd, m_wr, m_wb, m_imm, m_b, m_us, m_undef} = '0;
            m_cmd = 0; m_shadow = 0; m_count = 0;
        end else if (flush) begin
            {m_valid, m_rd, m_wr, m_wb, m_imm, m_b, m_us, m_undef} = '0;
            m_cmd = 0; m_shadow = 0;
        end else if (freeze) begin
            m_undef = 0;
        end else begin
            live = id_valid && cond_ok(cond, status) && m_shadow == 0;
            {m_valid, m_rd, m_wr, m_wb, m_imm, m_b, m_us, m_undef} = '0;
            m_cmd = 0;
            if (live) begin
                m_valid = 1;
                m_count = (m_count + 1) % (1 << CNT_W);
                if (mode == 0) begin
                    m_wb = 1; m_imm = immediate; m_us = S;
                    case (op_code)
                        4'b1101: m_cmd = 1;  4'b1111: m_cmd = 9;
                        4'b0100: m_cmd = 2;  4'b0101: m_cmd = 3;
                        4'b0010: m_cmd = 4;  4'b0110: m_cmd = 5;
                        4'b0000: m_cmd = 6;  4'b1100: m_cmd = 7;
                        4'b0001: m_cmd = 8;
                        4'b1010: begin m_cmd = 4; m_wb = 0; end
                        4'b1000: begin m_cmd = 6; m_wb = 0; end
                        default: m_cmd = 0;
                    endcase
                end else if (mode == 1) begin
                    m_cmd = 2; m_imm = immediate;
                    m_rd = S; m_wb = S; m_wr = !S;
                end else if (mode == 2) begin
                    m_b = 1;
                end else begin
                    m_undef = 1;
                end
            end
            if (live && mode == 2) m_shadow = BRANCH_SHADOW;
            else if (m_shadow > 0) m_shadow--;
        end
    endtask

    task automatic step(input string tag, input bit r, input bit v, input bit [1:0] md,
                        input bit [3:0] op, input bit s, input bit i, input bit [3:0] cd,
                        input bit [3:0] st, input bit fz, input bit fl);
        rst = r; id_valid = v; mode = md; op_code = op; S = s; immediate = i;
        cond = cd; status = st; freeze = fz; flush = fl;
        @(posedge clk);
        #1;
        model_clock();
        check({tag, ".ctrl"},
              32'({ex_valid, ex_exe_command, ex_mem_read, ex_mem_write, ex_wb_enable,
                   ex_is_immediate, ex_B, ex_update_status, undef_instr, shadow_active}),
              32'({m_valid, m_cmd, m_rd, m_wr, m_wb, m_imm, m_b, m_us, m_undef,
                   m_shadow != 0}));
        check({tag, ".count"}, 32'(issued_count), 32'(m_count));
    endtask

    initial begin
        // Reset
        step("reset0", 1, 0, 0, 0, 0, 0, 4'he, 0, 0, 0);
        step("reset1", 1, 0, 0, 0, 0, 0, 4'he, 0, 0, 0);
        check("reset_valid", 32'(ex_valid), 32'd0);

        // ADD, S=1, AL
        step("add", 0, 1, 0, 4'b0100, 1, 0, 4'he, 0, 0, 0);
        check("add_cmd", 32'(ex_exe_command), 32'd2);
        check("add_us", 32'(ex_update_status), 32'd1);
        check("add_cnt", 32'(issued_count), 32'd1);

        // EQ failing then passing
        step("eq_fail", 0, 1, 0, 4'b1101, 0, 1, 4'h0, 4'b0000, 0, 0);
        check("eq_fail_valid", 32'(ex_valid), 32'd0);
        step("eq_pass", 0, 1, 0, 4'b1101, 0, 1, 4'h0, 4'b0100, 0, 0);
        check("eq_pass_cmd", 32'(ex_exe_command), 32'd1);
        step("never", 0, 1, 0, 4'b0100, 0, 0, 4'hf, 0, 0, 0);

        // Branch then two ADDs: first squashed, second issues
        step("br", 0, 1, 2, 0, 0, 0, 4'he, 0, 0, 0);
        check("br_b", 32'(ex_B), 32'd1);
        step("br_sq", 0, 1, 0, 4'b0100, 0, 0, 4'he, 0, 0, 0);
        check("br_sq_valid", 32'(ex_valid), 32'd0);
        step("br_add", 0, 1, 0, 4'b0100, 0, 0, 4'he, 0, 0, 0);
        check("br_add_valid", 32'(ex_valid), 32'd1);

        // Reset mid-stream with shadow armed
        step("br2", 0, 1, 2, 0, 0, 0, 4'he, 0, 0, 0);
        check("br2_shadow", 32'(shadow_active), 32'd1);
        step("rst_mid", 1, 1, 0, 4'b0100, 0, 0, 4'he, 0, 0, 0);

        // LDR held through freeze, then flushed
        step("ldr", 0, 1, 1, 0, 1, 1, 4'he, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step("frz", 0, 1, 0, 4'b0010, 0, 0, 4'he, 0, 1, 0);
            check("frz_rd", 32'(ex_mem_read), 32'd1);
        end
        step("flush", 0, 1, 0, 4'b0010, 0, 0, 4'he, 0, 0, 1);
        check("flush_valid", 32'(ex_valid), 32'd0);
        step("str", 0, 1, 1, 0, 0, 0, 4'he, 0, 0, 0);

        // Counter wrap, then undefined-mode pulse
        step("rst_wrap", 1, 0, 0, 0, 0, 0, 4'he, 0, 0, 0);
        for (int k = 0; k < 16; k++) step("wrap", 0, 1, 0, 4'b0100, 0, 0, 4'he, 0, 0, 0);
        check("wrap_zero", 32'(issued_count), 32'd0);
        step("und", 0, 1, 3, 0, 0, 0, 4'he, 0, 0, 0);
        check("und_pulse", 32'(undef_instr), 32'd1);
        step("und_end", 0, 0, 0, 0, 0, 0, 4'he, 0, 0, 0);
        check("und_end_pulse", 32'(undef_instr), 32'd0);
        step("und_fail", 0, 1, 3, 0, 0, 0, 4'hf, 0, 0, 0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 1) != 0) ? 4'he : 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
